// File: rtl/logic_pkg.sv
// logic_pkg: shared definitions for the serial logic unit.
// Holds the 3-bit logic op encoding, the FSM state encoding and the
// per-slice control decode used by logic_slice.
package logic_pkg;

   // Logic op select encoding
   localparam logic [2:0] LOP_AND    = 3'b000;
   localparam logic [2:0] LOP_NAND   = 3'b001;
   localparam logic [2:0] LOP_OR     = 3'b010;
   localparam logic [2:0] LOP_NOR    = 3'b011;
   localparam logic [2:0] LOP_XOR    = 3'b100;
   localparam logic [2:0] LOP_XNOR   = 3'b101;
   localparam logic [2:0] LOP_PASS_A = 3'b110;
   localparam logic [2:0] LOP_NOT_A  = 3'b111;

   // Sequencer states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Which primitive feeds the final inversion stage of a slice
   typedef enum logic [1:0] {
      SRC_NAND = 2'd0,
      SRC_XOR  = 2'd1,
      SRC_A    = 2'd2
   } stage_sel_e;

   // Control word for one slice: optional input inversion ahead of the
   // NAND, primitive select, and output inversion.
   typedef struct packed {
      logic       inv_in;
      stage_sel_e sel;
      logic       inv_out;
   } slice_ctrl_t;

   // Every op is a NAND (with De Morgan input inversion for OR/NOR), an
   // XOR, or a pass of A, followed by an optional output inversion.
   function automatic slice_ctrl_t decode_op(input logic [2:0] op);
      slice_ctrl_t c;
      c = '{inv_in: 1'b0, sel: SRC_NAND, inv_out: 1'b0};
      case (op)
         LOP_AND:    c = '{inv_in: 1'b0, sel: SRC_NAND, inv_out: 1'b1};
         LOP_NAND:   c = '{inv_in: 1'b0, sel: SRC_NAND, inv_out: 1'b0};
         LOP_OR:     c = '{inv_in: 1'b1, sel: SRC_NAND, inv_out: 1'b0};
         LOP_NOR:    c = '{inv_in: 1'b1, sel: SRC_NAND, inv_out: 1'b1};
         LOP_XOR:    c = '{inv_in: 1'b0, sel: SRC_XOR,  inv_out: 1'b0};
         LOP_XNOR:   c = '{inv_in: 1'b0, sel: SRC_XOR,  inv_out: 1'b1};
         LOP_PASS_A: c = '{inv_in: 1'b0, sel: SRC_A,    inv_out: 1'b0};
         default:    c = '{inv_in: 1'b0, sel: SRC_A,    inv_out: 1'b1};
      endcase
      return c;
   endfunction

   // Slice counter width: clog2 of the slice count, never below one bit
   function automatic int cnt_width(input int nslice);
      return (nslice > 1) ? $clog2(nslice) : 1;
   endfunction

endpackage

// File: rtl/serial_logic_unit_if.sv
// serial_logic_unit_if: operand/result handshake bundle of the serial
// logic unit. The zero flag wire exists only when LOGIC_ZERO_FLAG_EN is
// defined.
interface serial_logic_unit_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             overflow;
`ifdef LOGIC_ZERO_FLAG_EN
   logic             zero;
`endif

   // Producer of operands / consumer of results
   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carryout, overflow
`ifdef LOGIC_ZERO_FLAG_EN
      , input zero
`endif
   );

   // The logic unit itself
   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carryout, overflow
`ifdef LOGIC_ZERO_FLAG_EN
      , output zero
`endif
   );
endinterface

// File: rtl/logic_slice.sv
// logic_slice: combinational SLICE-bit logic stage shared by all slices.
// Structure per bit: input inversion -> NAND -> primitive select ->
// XOR-based output inversion. This is the old AND/NAND stage widened to
// cover all eight ops.
module logic_slice
   import logic_pkg::*;
#(
   parameter int SLICE = 8
) (
   input  logic [2:0]       op,
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] y
);

   slice_ctrl_t ctrl;

   assign ctrl = decode_op(op);

   genvar gi;
   generate
      for (gi = 0; gi < SLICE; gi++) begin : g_bit
         logic a_in;
         logic b_in;
         logic nand_bit;
         logic xor_bit;
         logic stage_bit;

         // De Morgan: OR/NOR reuse the NAND with both inputs inverted
         assign a_in     = a[gi] ^ ctrl.inv_in;
         assign b_in     = b[gi] ^ ctrl.inv_in;
         assign nand_bit = ~(a_in & b_in);
         assign xor_bit  = a[gi] ^ b[gi];

         // Pick the primitive result that feeds the inversion stage
         always_comb begin
            stage_bit = nand_bit;
            case (ctrl.sel)
               SRC_NAND: stage_bit = nand_bit;
               SRC_XOR:  stage_bit = xor_bit;
               default:  stage_bit = a[gi];
            endcase
         end

         // XOR with the inversion control: 1 flips AND<-NAND, NOR<-OR, etc.
         assign y[gi] = stage_bit ^ ctrl.inv_out;
      end
   endgenerate

endmodule

// File: rtl/serial_logic_unit.sv
// serial_logic_unit: multi-mode bitwise logic unit that processes WIDTH-bit
// operands SLICE bits per cycle through one shared logic_slice, with
// valid/ready handshakes on both sides. carryout/overflow are kept as
// constant-zero ALU flags.
// Optional feature macro: LOGIC_ZERO_FLAG_EN adds a registered zero flag.
// WIDTH must be a multiple of SLICE.
module serial_logic_unit
   import logic_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic              clk,
   input  logic              reset,
   serial_logic_unit_if.slave bus
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CNT_W  = cnt_width(NSLICE);
   // With a single slice the whole result is produced on the accept edge
   localparam bit SINGLE = (NSLICE == 1);

   state_e             state_reg;
   state_e             state_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [2:0]         op_reg;
   logic [WIDTH-1:0]   result_reg;
   logic [WIDTH-1:0]   result_next;
   logic               out_valid_reg;

   logic               in_ready_int;
   logic               accept;
   logic               last_slice;
   logic [NSLICE-1:0]  wr_en;

   logic [SLICE-1:0]   a_slices [NSLICE];
   logic [SLICE-1:0]   b_slices [NSLICE];
   logic [2:0]         slice_op;
   logic [SLICE-1:0]   slice_a;
   logic [SLICE-1:0]   slice_b;
   logic [SLICE-1:0]   slice_y;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: accept from IDLE or on a DONE handshake, step through
   // BUSY until the last slice is written
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_next = SINGLE ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            if (last_slice) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  state_next = SINGLE ? S_DONE : S_BUSY;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Decoded controls; in_ready is the only combinational output
   always_comb begin
      in_ready_int = 1'b0;
      case (state_reg)
         S_IDLE:  in_ready_int = 1'b1;
         S_DONE:  in_ready_int = bus.out_ready;
         default: in_ready_int = 1'b0;
      endcase
      accept     = in_ready_int && bus.in_valid;
      last_slice = (state_reg == S_BUSY) && (cnt_reg == CNT_W'(NSLICE - 1));
   end

   // ------------------------------------------------------------------
   // Slice datapath
   // ------------------------------------------------------------------

   genvar gi;
   generate
      for (gi = 0; gi < NSLICE; gi++) begin : g_slice
         assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
         assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
         // Single-slice builds write on the accept edge, others one
         // slice per BUSY cycle in counter order
         assign wr_en[gi] = SINGLE ? accept
                                   : ((state_reg == S_BUSY) && (cnt_reg == CNT_W'(gi)));
      end
   endgenerate

   // Single-slice builds feed the live operands; otherwise the latched
   // copies are used so input changes during BUSY have no effect
   always_comb begin
      slice_op = SINGLE ? bus.op : op_reg;
      slice_a  = SINGLE ? bus.a[SLICE-1:0] : a_slices[cnt_reg];
      slice_b  = SINGLE ? bus.b[SLICE-1:0] : b_slices[cnt_reg];
   end

   logic_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .op (slice_op),
      .a  (slice_a),
      .b  (slice_b),
      .y  (slice_y)
   );

   // Merge the freshly computed slice into the result; unwritten slices
   // keep their old (stale) contents
   always_comb begin
      result_next = result_reg;
      for (int i = 0; i < NSLICE; i++) begin
         if (wr_en[i]) begin
            result_next[i*SLICE +: SLICE] = slice_y;
         end
      end
   end

   // Operand latches, slice counter, result and out_valid registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_reg         <= '0;
         b_reg         <= '0;
         op_reg        <= '0;
         cnt_reg       <= '0;
         result_reg    <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         if (accept) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            op_reg  <= bus.op;
            cnt_reg <= '0;
         end else if (state_reg == S_BUSY) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
         result_reg    <= result_next;
         out_valid_reg <= (state_next == S_DONE);
      end
   end

`ifdef LOGIC_ZERO_FLAG_EN
   logic zero_reg;

   // Zero flag follows out_valid: judged on the complete result as it
   // enters DONE, cleared whenever the unit is not presenting a result
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         zero_reg <= 1'b0;
      end else begin
         zero_reg <= (state_next == S_DONE) && (result_next == '0);
      end
   end

   assign bus.zero = zero_reg;
`endif

   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_reg;
   assign bus.result    = result_reg;
   assign bus.carryout  = 1'b0;
   assign bus.overflow  = 1'b0;

endmodule

// File: tb/tb_serial_logic_unit.sv
// tb_serial_logic_unit: self-checking bench for serial_logic_unit.
// Two instances: 32-bit/8-bit slices and 16-bit single-slice. A
// transaction-level model (one outstanding op per unit, fixed latency)
// is compared against each unit on every falling clock edge, alongside
// directed scenarios with literal expected results.
module tb_serial_logic_unit;
   import logic_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   serial_logic_unit_if #(.WIDTH(32)) b32 ();
   serial_logic_unit_if #(.WIDTH(16)) b16 ();

   serial_logic_unit #(.WIDTH(32), .SLICE(8)) dut32 (
      .clk   (clk),
      .reset (reset),
      .bus   (b32)
   );

   serial_logic_unit #(.WIDTH(16), .SLICE(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (b16)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Model state per unit: pending op, its result and accept edge number
   bit          pend  [2];
   logic [31:0] pres  [2];
   int          pedge [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return ~(a & b);
         3'd2: return a | b;
         3'd3: return ~(a | b);
         3'd4: return a ^ b;
         3'd5: return ~(a ^ b);
         3'd6: return a;
         default: return ~a;
      endcase
   endfunction

   // Edges from accept to out_valid: NSLICE, or the accept edge itself
   // for a single-slice unit
   function automatic int lat(input int d);
      return (d == 0) ? 4 : 0;
   endfunction

   function automatic bit exp_valid(input int d);
      return pend[d] && ((cyc - pedge[d]) >= lat(d));
   endfunction

   task automatic mon(input int d, input logic ov, input logic iry, input logic co,
                      input logic ovf, input logic iv, input logic ordy,
                      input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res);
      logic [31:0] mask;
      bit          e_ov;
      bit          e_ry;
      mask = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      if (reset) begin
         pend[d] = 1'b0;
         chk($sformatf("u%0d_rst_out_valid", d), ov, 0);
         chk($sformatf("u%0d_rst_result", d), res, 0);
         return;
      end
      e_ov = exp_valid(d);
      e_ry = !pend[d] || (e_ov && ordy);
      chk($sformatf("u%0d_out_valid", d), ov, e_ov);
      chk($sformatf("u%0d_in_ready", d), iry, e_ry);
      chk($sformatf("u%0d_carryout", d), co, 0);
      chk($sformatf("u%0d_overflow", d), ovf, 0);
      if (e_ov) chk($sformatf("u%0d_result", d), res, pres[d]);
      if (e_ov && ordy) begin
         $display("u%0d done: result=0x%0h accepted@%0d cyc=%0d", d, res, pedge[d], cyc);
         pend[d] = 1'b0;
      end
      if (iv && e_ry) begin
         pend[d]  = 1'b1;
         pres[d]  = ref_op(op, a & mask, b & mask) & mask;
         pedge[d] = cyc + 1;
      end
   endtask

   // Compare process: check both units against the model every cycle
   always @(negedge clk) begin
`ifdef LOGIC_ZERO_FLAG_EN
      chk("u0_zero", b32.zero, (!reset && exp_valid(0) && pres[0] == 32'h0) ? 1 : 0);
      chk("u1_zero", b16.zero, (!reset && exp_valid(1) && pres[1] == 32'h0) ? 1 : 0);
`endif
      mon(0, b32.out_valid, b32.in_ready, b32.carryout, b32.overflow, b32.in_valid,
          b32.out_ready, b32.op, b32.a, b32.b, b32.result);
      mon(1, b16.out_valid, b16.in_ready, b16.carryout, b16.overflow, b16.in_valid,
          b16.out_ready, b16.op, {16'h0, b16.a}, {16'h0, b16.b}, {16'h0, b16.result});
   end

   task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      if (d == 0) begin
         b32.in_valid = 1'b1; b32.op = op; b32.a = a; b32.b = b;
      end else begin
         b16.in_valid = 1'b1; b16.op = op; b16.a = a[15:0]; b16.b = b[15:0];
      end
      @(posedge clk); #1;
      if (d == 0) b32.in_valid = 1'b0;
      else        b16.in_valid = 1'b0;
   endtask

   task automatic wait_ov(input int d, output int k);
      k = 0;
      while (((d == 0) ? b32.out_valid : b16.out_valid) !== 1'b1 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
   endtask

   task automatic take(input int d);
      if (d == 0) b32.out_ready = 1'b1; else b16.out_ready = 1'b1;
      @(posedge clk); #1;
      if (d == 0) b32.out_ready = 1'b0; else b16.out_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int k;
      b32.in_valid = 0; b32.a = 0; b32.b = 0; b32.op = 0; b32.out_ready = 0;
      b16.in_valid = 0; b16.a = 0; b16.b = 0; b16.op = 0; b16.out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid32", b32.out_valid, 0);
      chk("reset_result32", b32.result, 0);
      chk("reset_result16", {16'h0, b16.result}, 0);
      reset = 1'b0;
      #1;
      chk("reset_in_ready32", b32.in_ready, 1);
      chk("reset_in_ready16", b16.in_ready, 1);
      @(posedge clk); #1;

      // AND: four-cycle latency
      issue(0, LOP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
      wait_ov(0, k);
      chk("t1_latency", k, 4);
      chk("t1_and", b32.result, 32'h0F0F_0000);
      chk("t1_carryout", b32.carryout, 0);
      chk("t1_overflow", b32.overflow, 0);
      take(0);
      chk("t1_idle_after_take", b32.out_valid, 0);

      // NAND then NOR on the same operands
      issue(0, LOP_NAND, 32'hFFFF_0000, 32'h0F0F_0F0F);
      wait_ov(0, k);
      chk("t2_nand", b32.result, 32'hF0F0_FFFF);
      take(0);
      issue(0, LOP_NOR, 32'hFFFF_0000, 32'h0F0F_0F0F);
      wait_ov(0, k);
      chk("t2_nor", b32.result, 32'h0000_F0F0);
      take(0);

      // Backpressure, then same-cycle accept on the handshake
      issue(0, LOP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
      wait_ov(0, k);
      repeat (10) begin
         @(posedge clk); #1;
         chk("t3_hold_result", b32.result, 32'h0F0F_0000);
         chk("t3_hold_in_ready", b32.in_ready, 0);
      end
      b32.out_ready = 1'b1;
      b32.in_valid = 1'b1; b32.op = LOP_XOR; b32.a = 32'h1234_5678; b32.b = 32'hFFFF_FFFF;
      #1;
      chk("t3_ready_on_handshake", b32.in_ready, 1);
      @(posedge clk); #1;
      b32.in_valid = 1'b0; b32.out_ready = 1'b0;
      b32.a = 32'h0; b32.op = LOP_AND;
      wait_ov(0, k);
      chk("t3_latency", k, 4);
      chk("t3_xor", b32.result, 32'hEDCB_A987);
      take(0);

      // Reset after two BUSY slices
      issue(0, LOP_OR, 32'h0F0F_00FF, 32'h00F0_F000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("t4_async_out_valid", b32.out_valid, 0);
      chk("t4_async_result", b32.result, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("t4_in_ready_after", b32.in_ready, 1);
      issue(0, LOP_AND, 32'hFFFF_0000, 32'h0F0F_0F0F);
      wait_ov(0, k);
      chk("t4_latency", k, 4);
      chk("t4_and", b32.result, 32'h0F0F_0000);
      take(0);

      // Zero result, then non-zero
      issue(0, LOP_XOR, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      wait_ov(0, k);
      chk("t5_xor_zero", b32.result, 32'h0);
`ifdef LOGIC_ZERO_FLAG_EN
      chk("t5_zero_set", b32.zero, 1);
`endif
      take(0);
      issue(0, LOP_PASS_A, 32'h0000_0001, 32'hA5A5_5A5A);
      wait_ov(0, k);
      chk("t5_pass_a", b32.result, 32'h1);
`ifdef LOGIC_ZERO_FLAG_EN
      chk("t5_zero_clear", b32.zero, 0);
`endif
      take(0);

      // Random traffic on the 32-bit unit
      repeat (600) begin
         b32.in_valid  = 1'($urandom_range(0, 1));
         b32.op        = 3'($urandom_range(0, 7));
         b32.a         = $urandom;
         b32.b         = $urandom;
         b32.out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      b32.in_valid = 1'b0; b32.out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      b32.out_ready = 1'b0;

      // Single-slice unit: result on the accept edge
      issue(1, LOP_NOT_A, 32'h0000_00FF, 32'h0);
      wait_ov(1, k);
      chk("t6_latency", k, 0);
      chk("t6_not_a", {16'h0, b16.result}, 32'h0000_FF00);
      b16.out_ready = 1'b1;
      b16.in_valid  = 1'b1;
      repeat (12) begin
         b16.op = 3'($urandom_range(0, 7));
         b16.a  = 16'($urandom);
         b16.b  = 16'($urandom);
         @(posedge clk); #1;
         chk("t6_b2b_valid", b16.out_valid, 1);
         chk("t6_b2b_ready", b16.in_ready, 1);
      end
      b16.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("t6_drained", b16.out_valid, 0);

      // Random traffic on the single-slice unit
      repeat (400) begin
         b16.in_valid  = 1'($urandom_range(0, 1));
         b16.op        = 3'($urandom_range(0, 7));
         b16.a         = 16'($urandom);
         b16.b         = 16'($urandom);
         b16.out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      b16.in_valid = 1'b0; b16.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
